alu_multiciclo: RTL and testbench

// - Execute-stage ALU downstream of the ALU control decoder; consumes its 4-bit sel code plus operands A/B.
// - Logic/arith ops complete in one cycle; MUL (shift-add) and DIV (restoring) iterate over WIDTH cycles.
// - Registered result with start/busy/done handshake so the control FSM stalls on long ops.

---
 rtl/alu_multiciclo_if.sv | 34 +++
 rtl/alu_multiciclo.sv | 193 +++++++++++++++++++
 tb/tb_alu_multiciclo.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_multiciclo_if.sv
// Request/response bundle between the execute control FSM and alu_multiciclo.
// Optional overflow flag present when ALU_MULTICICLO_OVF_EN is defined.
interface alu_multiciclo_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       sel;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             div_by_zero;
`ifdef ALU_MULTICICLO_OVF_EN
   logic             overflow;
`endif

   modport master (
      output start, sel, a, b,
`ifdef ALU_MULTICICLO_OVF_EN
      input  overflow,
`endif
      input  busy, done, result, zero, div_by_zero
   );

   modport slave (
      input  start, sel, a, b,
`ifdef ALU_MULTICICLO_OVF_EN
      output overflow,
`endif
      output busy, done, result, zero, div_by_zero
   );
endinterface

// File: rtl/alu_multiciclo.sv
// Execute-stage ALU: one-cycle logic/arith, WIDTH-cycle shift-add MUL and restoring DIV.
// Define ALU_MULTICICLO_OVF_EN to add the signed ADD/SUB overflow flag.
module alu_multiciclo #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_multiciclo_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b0011;
   localparam logic [3:0] OP_DIV = 4'b0100;
   localparam logic [3:0] OP_NOP = 4'b1000;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mcand, mplier, prod;
   logic [WIDTH-1:0] dq, dd, dr;
   logic             neg;
   logic             done_q, zero_q, dbz_q;
   logic [WIDTH-1:0] result_q;

   logic             accept, last, fin, dbz_n;
   logic [WIDTH-1:0] res_n, sum, dif, prod_n;
   logic [WIDTH-1:0] a_mag, b_mag, r_n, q_n, quot;
   logic [WIDTH:0]   shl, trial;
   logic             fit;

   assign accept = bus.start && (state == S_IDLE);
   assign last   = (cnt == CW'(WIDTH - 1));
   assign sum    = bus.a + bus.b;
   assign dif    = bus.a - bus.b;
   assign a_mag  = bus.a[WIDTH-1] ? -bus.a : bus.a;
   assign b_mag  = bus.b[WIDTH-1] ? -bus.b : bus.b;
   assign prod_n = mplier[0] ? prod + mcand : prod;

   // restoring step: shift next dividend bit into remainder, keep if divisor fits
   assign shl   = {dr, dq[WIDTH-1]};
   assign trial = shl - {1'b0, dd};
   assign fit   = !trial[WIDTH];
   assign r_n   = fit ? trial[WIDTH-1:0] : shl[WIDTH-1:0];
   assign q_n   = {dq[WIDTH-2:0], fit};
   assign quot  = neg ? -q_n : q_n;

   always_comb begin
      state_n = state;
      fin     = 1'b0;
      res_n   = '0;
      dbz_n   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               unique case (1'b1)
                  bus.sel == OP_MUL: state_n = S_MUL;
                  bus.sel == OP_DIV && bus.b == '0: begin
                     fin   = 1'b1;
                     res_n = '1;
                     dbz_n = 1'b1;
                  end
                  bus.sel == OP_DIV && bus.b != '0: state_n = S_DIV;
                  bus.sel == OP_AND: begin
                     fin   = 1'b1;
                     res_n = bus.a & bus.b;
                  end
                  bus.sel == OP_OR: begin
                     fin   = 1'b1;
                     res_n = bus.a | bus.b;
                  end
                  bus.sel == OP_SUB: begin
                     fin   = 1'b1;
                     res_n = dif;
                  end
                  bus.sel == OP_SLT: begin
                     fin   = 1'b1;
                     res_n = WIDTH'($signed(bus.a) < $signed(bus.b));
                  end
                  bus.sel == OP_NOP: fin = 1'b1;
                  default: begin
                     fin   = 1'b1;
                     res_n = sum;
                  end
               endcase
            end
         end
         S_MUL: begin
            if (last) begin
               fin     = 1'b1;
               res_n   = prod_n;
               state_n = S_IDLE;
            end
         end
         S_DIV: begin
            if (last) begin
               fin     = 1'b1;
               res_n   = quot;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         prod     <= '0;
         dq       <= '0;
         dd       <= '0;
         dr       <= '0;
         neg      <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         done_q <= fin;
         if (fin) begin
            result_q <= res_n;
            zero_q   <= (res_n == '0);
            dbz_q    <= dbz_n;
         end
         if (accept) begin
            cnt    <= '0;
            mcand  <= bus.a;
            mplier <= bus.b;
            prod   <= '0;
            dq     <= a_mag;
            dd     <= b_mag;
            dr     <= '0;
            neg    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
         end else if (state == S_MUL) begin
            prod   <= prod_n;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
         end else if (state == S_DIV) begin
            dq  <= q_n;
            dr  <= r_n;
            cnt <= cnt + 1'b1;
         end
      end
   end

`ifdef ALU_MULTICICLO_OVF_EN
   logic ovf_n, ovf_q, ovf_add, ovf_sub;

   assign ovf_add = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                    (sum[WIDTH-1] != bus.a[WIDTH-1]);
   assign ovf_sub = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                    (dif[WIDTH-1] != bus.a[WIDTH-1]);

   // only idle completions come from ADD/SUB; MUL/DIV finish with 0
   always_comb begin
      ovf_n = 1'b0;
      if (state == S_IDLE) begin
         unique case (bus.sel)
            OP_AND, OP_OR, OP_SLT,
            OP_MUL, OP_DIV, OP_NOP: ovf_n = 1'b0;
            OP_SUB:                 ovf_n = ovf_sub;
            default:                ovf_n = ovf_add;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   ovf_q <= 1'b0;
      else if (fin) ovf_q <= ovf_n;
   end

   assign bus.overflow = ovf_q;
`endif

   assign bus.busy        = (state != S_IDLE);
   assign bus.done        = done_q;
   assign bus.result      = result_q;
   assign bus.zero        = zero_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_multiciclo.sv
// Scoreboard bench for alu_multiciclo: directed ops, latency/busy checks, mid-op reset.
// Overflow expectations are compared when ALU_MULTICICLO_OVF_EN is defined.
module tb_alu_multiciclo;
   localparam int W = 32;

   localparam logic [3:0] AND_ = 4'b0000;
   localparam logic [3:0] OR_  = 4'b0001;
   localparam logic [3:0] ADD_ = 4'b0010;
   localparam logic [3:0] SUB_ = 4'b0110;
   localparam logic [3:0] SLT_ = 4'b0111;
   localparam logic [3:0] MUL_ = 4'b0011;
   localparam logic [3:0] DIV_ = 4'b0100;
   localparam logic [3:0] NOP_ = 4'b1000;

   typedef struct {
      logic [W-1:0] res;
      logic         dbz;
      logic         ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   alu_multiciclo_if #(.WIDTH(W)) bus ();

   alu_multiciclo #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=%h expected=none",
                     bus.result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", bus.result, e.res);
            chk("zero", W'(bus.zero), W'(e.res == '0));
            chk("div_by_zero", W'(bus.div_by_zero), W'(e.dbz));
`ifdef ALU_MULTICICLO_OVF_EN
            chk("overflow", W'(bus.overflow), W'(e.ovf));
`endif
         end
      end
   end

   task automatic op(input logic [3:0] s, input logic [W-1:0] x, y,
                     input logic [W-1:0] r, input logic dz, ov,
                     input int lat, input int bcyc, input int poke);
      int   n;
      int   nb;
      bit   got;
      exp_t e;
      @(negedge clk);
      bus.start = 1'b1;
      bus.sel   = s;
      bus.a     = x;
      bus.b     = y;
      e.res = r;
      e.dbz = dz;
      e.ovf = ov;
      sb.push_back(e);
      n   = 0;
      nb  = 0;
      got = 1'b0;
      while (!got && n < 60) begin
         @(negedge clk);
         n++;
         bus.start = 1'b0;
         if (n == poke) begin
            bus.start = 1'b1;
            bus.sel   = ADD_;
            bus.a     = 1;
            bus.b     = 1;
         end
         if (bus.busy) nb++;
         if (bus.done) got = 1'b1;
      end
      bus.start = 1'b0;
      chk("done_seen", W'(got), W'(1));
      chk("latency", W'(n), W'(lat));
      chk("busy_cycles", W'(nb), W'(bcyc));
   endtask

   initial begin
      int n;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.sel   = 4'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", W'(bus.busy), '0);
      chk("rst_done", W'(bus.done), '0);
      chk("rst_result", bus.result, '0);
      chk("rst_zero", W'(bus.zero), '0);
      chk("rst_dbz", W'(bus.div_by_zero), '0);
      rst_n = 1'b1;
      @(negedge clk);

      op(ADD_, 7, 5, 12, 0, 0, 1, 0, 0);
      op(SUB_, 5, 5, 0, 0, 0, 1, 0, 0);
      op(SLT_, 32'hFFFF_FFFD, 2, 1, 0, 0, 1, 0, 0);
      op(SLT_, 2, 32'hFFFF_FFFD, 0, 0, 0, 1, 0, 0);
      op(AND_, 32'hF0F0, 32'h0FF0, 32'h00F0, 0, 0, 1, 0, 0);
      op(OR_, 32'hF0F0, 32'h0FF0, 32'hFFF0, 0, 0, 1, 0, 0);
      op(NOP_, 9, 9, 0, 0, 0, 1, 0, 0);
      op(4'b1111, 10, 20, 30, 0, 0, 1, 0, 0);
      op(MUL_, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFD, 0, 0, W + 1, W, 5);
      op(MUL_, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 6, 0, 0, W + 1, W, 0);
      op(MUL_, 7, 6, 42, 0, 0, W + 1, W, 0);
      op(DIV_, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 0, 0, W + 1, W, 0);
      op(DIV_, 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 0, W + 1, W, 0);
      op(DIV_, 7, 0, 32'hFFFF_FFFF, 1, 0, 1, 0, 0);
      op(DIV_, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0,
         W + 1, W, 0);
      op(DIV_, 1, 5, 0, 0, 0, W + 1, W, 0);
      op(DIV_, 100, 3, 33, 0, 0, W + 1, W, 0);

      @(negedge clk);
      bus.start = 1'b1;
      bus.sel   = DIV_;
      bus.a     = 100;
      bus.b     = 3;
      n = 0;
      while (n < 10) begin
         @(negedge clk);
         n++;
         bus.start = 1'b0;
      end
      chk("pre_rst_busy", W'(bus.busy), W'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", W'(bus.busy), '0);
      chk("mid_rst_done", W'(bus.done), '0);
      chk("mid_rst_result", bus.result, '0);
      chk("mid_rst_zero", W'(bus.zero), '0);
      chk("mid_rst_dbz", W'(bus.div_by_zero), '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 4) @(negedge clk);
      chk("no_done_after_abort", W'(bus.done), '0);
      op(ADD_, 1, 1, 2, 0, 0, 1, 0, 0);

      op(ADD_, 32'h7FFF_FFFF, 1, 32'h8000_0000, 0, 1, 1, 0, 0);
      op(SUB_, 32'h8000_0000, 1, 32'h7FFF_FFFF, 0, 1, 1, 0, 0);
      op(ADD_, 1, 1, 2, 0, 0, 1, 0, 0);

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", W'(sb.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
